// File: rtl/float_cmp_issuer_if.sv
// Bundled request, compare-core stream and response signals for float_cmp_issuer.
interface float_cmp_issuer_if #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MAX_OUT = 4
);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic              req_valid;
    logic              req_ready;
    logic [SIZE-1:0]   req_a;
    logic [SIZE-1:0]   req_b;
    logic [TAG_W-1:0]  req_tag;

    logic [SIZE-1:0]   m_axis_a_tdata;
    logic              m_axis_a_tvalid;
    logic              m_axis_a_tready;
    logic [SIZE-1:0]   m_axis_b_tdata;
    logic              m_axis_b_tvalid;
    logic              m_axis_b_tready;

    logic [7:0]        s_axis_result_tdata;
    logic              s_axis_result_tvalid;
    logic              s_axis_result_tready;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_lt;
    logic [TAG_W-1:0]  resp_tag;

    logic [CNT_W-1:0]  outstanding;
    logic              err_orphan;

    // Issuer side
    modport slave (
        input  req_valid, req_a, req_b, req_tag,
        input  m_axis_a_tready, m_axis_b_tready,
        input  s_axis_result_tdata, s_axis_result_tvalid,
        input  resp_ready,
        output req_ready,
        output m_axis_a_tdata, m_axis_a_tvalid, m_axis_b_tdata, m_axis_b_tvalid,
        output s_axis_result_tready,
        output resp_valid, resp_lt, resp_tag,
        output outstanding, err_orphan
    );

    // Requester / compare-core / consumer side
    modport master (
        output req_valid, req_a, req_b, req_tag,
        output m_axis_a_tready, m_axis_b_tready,
        output s_axis_result_tdata, s_axis_result_tvalid,
        output resp_ready,
        input  req_ready,
        input  m_axis_a_tdata, m_axis_a_tvalid, m_axis_b_tdata, m_axis_b_tvalid,
        input  s_axis_result_tready,
        input  resp_valid, resp_lt, resp_tag,
        input  outstanding, err_orphan
    );
endinterface

// File: rtl/float_cmp_issuer.sv
// Issues float compare operand pairs to an external compare core and returns
// the less-than results to the caller in issue order, tagged.
module float_cmp_issuer #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input logic               aclk,
    input logic               aresetn,
    float_cmp_issuer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t            state;
    logic [SIZE-1:0]   a_q;
    logic [SIZE-1:0]   b_q;
    logic [TAG_W-1:0]  tag_q;
    logic              a_tvalid_q;
    logic              b_tvalid_q;
    logic              req_ready_q;
    logic              alive_q;
    logic              resp_valid_q;
    logic              resp_lt_q;
    logic [TAG_W-1:0]  resp_tag_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [TAG_W-1:0]  fifo_mem [MAX_OUT];

    logic              req_hs;
    logic              a_hs;
    logic              b_hs;
    logic              issue_done;
    logic              res_tready;
    logic              res_hs;
    logic              push;
    logic              pop;
    logic              orphan;
    logic              next_idle;
    logic [CNT_W-1:0]  count_nxt;
    logic              unused_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode; a channel counts as done once its tvalid has dropped
    // or it handshakes this cycle.
    assign req_hs     = bus.req_valid && req_ready_q;
    assign a_hs       = a_tvalid_q && bus.m_axis_a_tready;
    assign b_hs       = b_tvalid_q && bus.m_axis_b_tready;
    assign issue_done = (state == ISSUE) && (!a_tvalid_q || a_hs) && (!b_tvalid_q || b_hs);
    assign res_tready = alive_q && (!resp_valid_q || bus.resp_ready);
    assign res_hs     = bus.s_axis_result_tvalid && res_tready;
    assign push       = issue_done;
    assign pop        = res_hs && (count_q != '0);
    assign orphan     = res_hs && (count_q == '0);
    assign next_idle  = ((state == IDLE) && !req_hs) || issue_done;
    assign unused_ok  = ^bus.s_axis_result_tdata[7:1];

    always_comb begin
        count_nxt = count_q;
        if (push && !pop)
            count_nxt = count_q + CNT_W'(1);
        else if (!push && pop)
            count_nxt = count_q - CNT_W'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            a_tvalid_q   <= 1'b0;
            b_tvalid_q   <= 1'b0;
            req_ready_q  <= 1'b0;
            alive_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_lt_q    <= 1'b0;
            resp_tag_q   <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            alive_q     <= 1'b1;
            count_q     <= count_nxt;
            req_ready_q <= next_idle && (count_nxt < CNT_W'(MAX_OUT));

            case (state)
                IDLE: begin
                    if (req_hs) begin
                        state      <= ISSUE;
                        a_q        <= bus.req_a;
                        b_q        <= bus.req_b;
                        tag_q      <= bus.req_tag;
                        a_tvalid_q <= 1'b1;
                        b_tvalid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (a_hs)       a_tvalid_q <= 1'b0;
                    if (b_hs)       b_tvalid_q <= 1'b0;
                    if (issue_done) state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (push) wr_ptr <= ptr_inc(wr_ptr);

            // A newly loaded result wins over draining the response register.
            if (pop) begin
                rd_ptr       <= ptr_inc(rd_ptr);
                resp_valid_q <= 1'b1;
                resp_lt_q    <= bus.s_axis_result_tdata[0];
                resp_tag_q   <= fifo_mem[rd_ptr];
            end else if (resp_valid_q && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end

            if (orphan) err_q <= 1'b1;
        end
    end

    // Tag storage; emptiness is tracked by count_q, so contents need no reset.
    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr] <= tag_q;
    end

    assign bus.req_ready            = req_ready_q;
    assign bus.m_axis_a_tdata       = a_q;
    assign bus.m_axis_a_tvalid      = a_tvalid_q;
    assign bus.m_axis_b_tdata       = b_q;
    assign bus.m_axis_b_tvalid      = b_tvalid_q;
    assign bus.s_axis_result_tready = res_tready;
    assign bus.resp_valid           = resp_valid_q;
    assign bus.resp_lt              = resp_lt_q;
    assign bus.resp_tag             = resp_tag_q;
    assign bus.outstanding          = count_q;
    assign bus.err_orphan           = err_q;
endmodule

// File: tb/tb_float_cmp_issuer.sv
// Self-checking bench for float_cmp_issuer: vector table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_float_cmp_issuer;
    localparam int unsigned SIZE    = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned MAX_OUT = 4;
    localparam int          OUT_LIM = 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    float_cmp_issuer_if #(.SIZE(SIZE), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)) bus ();

    float_cmp_issuer #(.SIZE(SIZE), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [7:0]  res;
        logic        exp_lt;
        logic [3:0]  exp_tag;
    } vec_t;

    typedef struct {
        logic [3:0] tag;
        logic       lt;
    } rsp_t;

    vec_t vecs [6];

    // Reference model state
    logic [3:0]  tagq  [$];
    logic [7:0]  coreq [$];
    rsp_t        expq  [$];
    bit          busy  = 1'b0;
    bit          a_got = 1'b0;
    bit          b_got = 1'b0;
    logic [31:0] cur_a = '0;
    logic [31:0] cur_b = '0;
    logic [3:0]  cur_tag = '0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
    endtask

    task automatic idle_inputs();
        bus.req_valid            = 1'b0;
        bus.req_a                = '0;
        bus.req_b                = '0;
        bus.req_tag              = '0;
        bus.m_axis_a_tready      = 1'b0;
        bus.m_axis_b_tready      = 1'b0;
        bus.s_axis_result_tdata  = '0;
        bus.s_axis_result_tvalid = 1'b0;
        bus.resp_ready           = 1'b0;
    endtask

    // Offer one request with both treadies high; returns at the negedge after issue.
    task automatic issue_one(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int waited;
        bus.req_a = a; bus.req_b = b; bus.req_tag = tag; bus.req_valid = 1'b1;
        bus.m_axis_a_tready = 1'b1; bus.m_axis_b_tready = 1'b1;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk_b("issue_req_ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        tick();
    endtask

    task automatic return_result(input logic [7:0] res, input logic exp_lt, input logic [3:0] exp_tag);
        bus.s_axis_result_tdata = res; bus.s_axis_result_tvalid = 1'b1; bus.resp_ready = 1'b1;
        tick();
        bus.s_axis_result_tvalid = 1'b0;
        chk_b("ret_resp_valid", bus.resp_valid, 1'b1);
        chk_b("ret_resp_lt", bus.resp_lt, exp_lt);
        chk_w("ret_resp_tag", 32'(bus.resp_tag), 32'(exp_tag));
        tick();
        chk_b("ret_resp_drained", bus.resp_valid, 1'b0);
    endtask

    // One random cycle: check outputs against the model, drive, predict the edge.
    task automatic rand_cycle(input bit allow_new);
        bit         m_rdy;
        bit         hs_req, hs_a, hs_b, hs_res, hs_resp;
        logic [7:0] rb;
        logic [3:0] t;
        m_rdy = !busy && (tagq.size() < OUT_LIM);
        chk_w("rnd_outstanding", 32'(bus.outstanding), 32'(tagq.size()));
        chk_b("rnd_req_ready", bus.req_ready, m_rdy);
        chk_b("rnd_a_tvalid", bus.m_axis_a_tvalid, busy && !a_got);
        chk_b("rnd_b_tvalid", bus.m_axis_b_tvalid, busy && !b_got);
        if (busy && !a_got) chk_w("rnd_a_tdata", bus.m_axis_a_tdata, cur_a);
        if (busy && !b_got) chk_w("rnd_b_tdata", bus.m_axis_b_tdata, cur_b);
        chk_b("rnd_resp_valid", bus.resp_valid, expq.size() != 0);
        if (expq.size() != 0) begin
            chk_b("rnd_resp_lt", bus.resp_lt, expq[0].lt);
            chk_w("rnd_resp_tag", 32'(bus.resp_tag), 32'(expq[0].tag));
        end
        chk_b("rnd_err_orphan", bus.err_orphan, 1'b0);

        bus.req_valid       = allow_new && ($urandom_range(0, 2) != 0);
        bus.req_a           = $urandom;
        bus.req_b           = $urandom;
        bus.req_tag         = 4'($urandom);
        bus.m_axis_a_tready = ($urandom_range(0, 3) != 0);
        bus.m_axis_b_tready = ($urandom_range(0, 3) != 0);
        bus.resp_ready      = ($urandom_range(0, 3) != 0);
        if (coreq.size() != 0) begin
            bus.s_axis_result_tvalid = ($urandom_range(0, 2) != 0);
            bus.s_axis_result_tdata  = coreq[0];
        end else begin
            bus.s_axis_result_tvalid = 1'b0;
            bus.s_axis_result_tdata  = 8'($urandom);
        end
        #1;
        chk_b("rnd_res_tready", bus.s_axis_result_tready, (expq.size() == 0) || bus.resp_ready);

        hs_req  = bus.req_valid && m_rdy;
        hs_a    = busy && !a_got && bus.m_axis_a_tready;
        hs_b    = busy && !b_got && bus.m_axis_b_tready;
        hs_res  = bus.s_axis_result_tvalid && ((expq.size() == 0) || bus.resp_ready);
        hs_resp = (expq.size() != 0) && bus.resp_ready;

        if (hs_resp) void'(expq.pop_front());
        if (hs_res) begin
            rb = coreq.pop_front();
            t  = tagq.pop_front();
            expq.push_back('{tag: t, lt: rb[0]});
        end
        if (hs_a) a_got = 1'b1;
        if (hs_b) b_got = 1'b1;
        if (busy && a_got && b_got) begin
            tagq.push_back(cur_tag);
            coreq.push_back(8'($urandom));
            busy = 1'b0;
        end
        if (hs_req) begin
            busy = 1'b1; a_got = 1'b0; b_got = 1'b0;
            cur_a = bus.req_a; cur_b = bus.req_b; cur_tag = bus.req_tag;
        end
        tick();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk_b({name, "_req_ready"}, bus.req_ready, 1'b0);
        chk_b({name, "_a_tvalid"}, bus.m_axis_a_tvalid, 1'b0);
        chk_b({name, "_b_tvalid"}, bus.m_axis_b_tvalid, 1'b0);
        chk_b({name, "_resp_valid"}, bus.resp_valid, 1'b0);
        chk_b({name, "_res_tready"}, bus.s_axis_result_tready, 1'b0);
        chk_w({name, "_outstanding"}, 32'(bus.outstanding), 32'd0);
        chk_b({name, "_err_orphan"}, bus.err_orphan, 1'b0);
        chk_w({name, "_a_tdata"}, bus.m_axis_a_tdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 4'd5,  8'h01, 1'b1, 4'd5};
        vecs[1] = '{32'h4000_0000, 32'h3F80_0000, 4'd3,  8'h00, 1'b0, 4'd3};
        vecs[2] = '{32'hBF80_0000, 32'h0000_0000, 4'd9,  8'hFF, 1'b1, 4'd9};
        vecs[3] = '{32'h7FC0_0000, 32'h3F80_0000, 4'd15, 8'hFE, 1'b0, 4'd15};
        vecs[4] = '{32'h0000_0000, 32'h8000_0000, 4'd0,  8'h80, 1'b0, 4'd0};
        vecs[5] = '{32'h7F7F_FFFF, 32'h7F80_0000, 4'd10, 8'h81, 1'b1, 4'd10};

        idle_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        chk_reset_outputs("rst");
        aresetn = 1'b1;
        #1;
        chk_b("rst_rel_ready_low", bus.req_ready, 1'b0);
        tick();
        chk_b("rst_first_ready", bus.req_ready, 1'b1);

        // Vector table: single compare each, latency and data checks
        for (int i = 0; i < 6; i++) begin
            bus.req_a = vecs[i].a; bus.req_b = vecs[i].b; bus.req_tag = vecs[i].tag;
            bus.req_valid = 1'b1; bus.m_axis_a_tready = 1'b1; bus.m_axis_b_tready = 1'b1;
            bus.resp_ready = 1'b1;
            chk_b("vec_req_ready", bus.req_ready, 1'b1);
            tick();
            bus.req_valid = 1'b0;
            chk_b("vec_a_tvalid", bus.m_axis_a_tvalid, 1'b1);
            chk_b("vec_b_tvalid", bus.m_axis_b_tvalid, 1'b1);
            chk_w("vec_a_tdata", bus.m_axis_a_tdata, vecs[i].a);
            chk_w("vec_b_tdata", bus.m_axis_b_tdata, vecs[i].b);
            chk_b("vec_busy_ready", bus.req_ready, 1'b0);
            tick();
            chk_b("vec_a_done", bus.m_axis_a_tvalid, 1'b0);
            chk_b("vec_b_done", bus.m_axis_b_tvalid, 1'b0);
            chk_w("vec_outstanding1", 32'(bus.outstanding), 32'd1);
            chk_b("vec_ready_again", bus.req_ready, 1'b1);
            return_result(vecs[i].res, vecs[i].exp_lt, vecs[i].exp_tag);
            chk_w("vec_outstanding0", 32'(bus.outstanding), 32'd0);
        end

        // B channel stalls three cycles while A completes at once
        bus.req_a = 32'h4120_0000; bus.req_b = 32'h40A0_0000; bus.req_tag = 4'd6;
        bus.req_valid = 1'b1; bus.m_axis_a_tready = 1'b1; bus.m_axis_b_tready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_b("stall_a_tvalid", bus.m_axis_a_tvalid, i == 0);
            chk_b("stall_b_tvalid", bus.m_axis_b_tvalid, 1'b1);
            chk_w("stall_b_tdata", bus.m_axis_b_tdata, 32'h40A0_0000);
            chk_w("stall_outstanding", 32'(bus.outstanding), 32'd0);
            chk_b("stall_req_ready", bus.req_ready, 1'b0);
            tick();
        end
        chk_b("stall_b_tvalid4", bus.m_axis_b_tvalid, 1'b1);
        bus.m_axis_b_tready = 1'b1;
        tick();
        chk_b("stall_b_done", bus.m_axis_b_tvalid, 1'b0);
        chk_w("stall_push", 32'(bus.outstanding), 32'd1);
        tick();
        chk_w("stall_single_push", 32'(bus.outstanding), 32'd1);
        return_result(8'h00, 1'b0, 4'd6);

        // Fill all slots; fifth request must be held off
        for (int t = 0; t < 4; t++) issue_one($urandom, $urandom, 4'(t));
        chk_w("full_outstanding", 32'(bus.outstanding), 32'd4);
        chk_b("full_req_ready", bus.req_ready, 1'b0);
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk_b("full_held_off", bus.m_axis_a_tvalid, 1'b0);
        chk_b("full_req_ready2", bus.req_ready, 1'b0);
        bus.s_axis_result_tdata = 8'h01; bus.s_axis_result_tvalid = 1'b1; bus.resp_ready = 1'b1;
        tick();
        bus.s_axis_result_tvalid = 1'b0;
        chk_b("full_freed_ready", bus.req_ready, 1'b1);
        chk_w("full_outstanding3", 32'(bus.outstanding), 32'd3);
        chk_w("full_first_tag", 32'(bus.resp_tag), 32'd0);
        tick();
        for (int t = 1; t < 4; t++) return_result(8'(t), t[0], 4'(t));

        // Response back-pressure with two results pending
        bus.resp_ready = 1'b0;
        issue_one(32'h1, 32'h2, 4'd1);
        issue_one(32'h3, 32'h4, 4'd2);
        bus.s_axis_result_tdata = 8'h01; bus.s_axis_result_tvalid = 1'b1;
        #1;
        chk_b("bp_tready_empty", bus.s_axis_result_tready, 1'b1);
        tick();
        chk_b("bp_resp1_valid", bus.resp_valid, 1'b1);
        chk_w("bp_resp1_tag", 32'(bus.resp_tag), 32'd1);
        bus.s_axis_result_tdata = 8'h00;
        #1;
        chk_b("bp_tready_full", bus.s_axis_result_tready, 1'b0);
        tick();
        chk_w("bp_resp1_held", 32'(bus.resp_tag), 32'd1);
        chk_b("bp_resp1_lt", bus.resp_lt, 1'b1);
        chk_w("bp_outstanding1", 32'(bus.outstanding), 32'd1);
        bus.resp_ready = 1'b1;
        #1;
        chk_b("bp_tready_pass", bus.s_axis_result_tready, 1'b1);
        tick();
        bus.s_axis_result_tvalid = 1'b0;
        chk_b("bp_resp2_valid", bus.resp_valid, 1'b1);
        chk_w("bp_resp2_tag", 32'(bus.resp_tag), 32'd2);
        chk_b("bp_resp2_lt", bus.resp_lt, 1'b0);
        chk_w("bp_outstanding0", 32'(bus.outstanding), 32'd0);
        tick();
        chk_b("bp_drained", bus.resp_valid, 1'b0);

        // Orphan result
        bus.s_axis_result_tdata = 8'h01; bus.s_axis_result_tvalid = 1'b1;
        tick();
        bus.s_axis_result_tvalid = 1'b0;
        chk_b("orphan_err", bus.err_orphan, 1'b1);
        chk_b("orphan_no_resp", bus.resp_valid, 1'b0);
        chk_w("orphan_outstanding", 32'(bus.outstanding), 32'd0);
        repeat (3) tick();
        chk_b("orphan_sticky", bus.err_orphan, 1'b1);
        chk_b("orphan_no_resp2", bus.resp_valid, 1'b0);

        // Reset with three compares in flight and one mid-issue
        for (int t = 0; t < 3; t++) issue_one($urandom, $urandom, 4'(t + 8));
        chk_w("mid_outstanding3", 32'(bus.outstanding), 32'd3);
        bus.req_valid = 1'b1; bus.m_axis_a_tready = 1'b1; bus.m_axis_b_tready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        aresetn = 1'b1;
        bus.m_axis_a_tready = 1'b1; bus.m_axis_b_tready = 1'b1; bus.resp_ready = 1'b1;
        tick();
        chk_b("midrst_ready", bus.req_ready, 1'b1);
        chk_w("midrst_outstanding", 32'(bus.outstanding), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk_b("midrst_no_stale", bus.resp_valid, 1'b0);
            chk_b("midrst_b_tvalid", bus.m_axis_b_tvalid, 1'b0);
            tick();
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
        guard = 0;
        while ((busy || tagq.size() != 0 || expq.size() != 0) && guard < 500) begin
            rand_cycle(1'b0);
            guard++;
        end
        if (guard >= 500) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: model still holds %0d tags, %0d responses", tagq.size(), expq.size());
        end
        chk_w("end_outstanding", 32'(bus.outstanding), 32'd0);
        chk_b("end_resp_valid", bus.resp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
